// File: rtl/wdt_pkg.sv
// Shared types for the watchdog kicker: FSM state encoding, the reload
// register address and the single-cycle bus write record.
package wdt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_KICK   = 3'd3,
        ST_STARVE = 3'd4,
        ST_DISARM = 3'd5,
        ST_ESCAL  = 3'd6,
        ST_RESET  = 3'd7
    } wdt_state_t;

    localparam logic [3:0] WDT_RELOAD_ADDR = 4'b0100;

    // Widest watchdog data bus the bus record can carry.
    localparam int WDT_MAX_NBIT = 64;

    typedef struct packed {
        logic [3:0]              addr;
        logic [WDT_MAX_NBIT-1:0] dout;
        logic                    req;
        logic                    we;
    } wdt_bus_t;

    // Counter width for a count parameter: $clog2, never below one bit.
    function automatic int wdt_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wdt_kick_timer.sv
// Loadable down-counter with a zero flag; used for the kick period,
// grace and reset-pulse counters. Decrement stops at zero.
module wdt_kick_timer #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; counter never wraps below zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= val_i;
        end else if (dec_i && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_o = (cnt == '0);

endmodule

// File: rtl/wdt_kicker.sv
// Watchdog kicker: arms the watchdog, reloads it every KICK_PERIOD cycles
// while software heartbeats keep arriving, stops kicking when they vanish,
// and after a watchdog timeout waits GRACE cycles before pulsing a reset
// request for RST_LEN cycles.
// Optional status outputs are built when WDT_KICKER_STATUS_EN is defined.
module wdt_kicker
    import wdt_pkg::*;
#(
    parameter int NBIT        = 32,
    parameter int RELOAD      = 1000,
    parameter int KICK_PERIOD = 256,
    parameter int GRACE       = 16,
    parameter int RST_LEN     = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            heartbeat_i,
    output logic [3:0]      wd_addr_o,
    output logic [NBIT-1:0] wd_dout_o,
    output logic            wd_req_o,
    output logic            wd_we_o,
    input  logic            wd_to_i,
    output logic            rst_req_o,
    output logic            active_o
`ifdef WDT_KICKER_STATUS_EN
    ,
    output logic [15:0]     kick_cnt_o,
    output logic [7:0]      starve_cnt_o,
    output logic            last_to_o
`endif
);

    if (RELOAD <= KICK_PERIOD) begin : g_bad_reload
        $error("wdt_kicker: RELOAD must exceed KICK_PERIOD");
    end
    if (KICK_PERIOD < 2) begin : g_bad_period
        $error("wdt_kicker: KICK_PERIOD must be at least 2");
    end
    if (GRACE < 1) begin : g_bad_grace
        $error("wdt_kicker: GRACE must be at least 1");
    end
    if (RST_LEN < 1) begin : g_bad_rst_len
        $error("wdt_kicker: RST_LEN must be at least 1");
    end
    if (NBIT > WDT_MAX_NBIT || NBIT < 1) begin : g_bad_nbit
        $error("wdt_kicker: NBIT out of supported range");
    end

    localparam int PW = wdt_cnt_w(KICK_PERIOD);
    localparam int GW = wdt_cnt_w(GRACE);
    localparam int RW = wdt_cnt_w(RST_LEN);

    // ARM/KICK occupies one cycle and WAIT counts down to zero inclusive,
    // so loading KICK_PERIOD-2 spaces the writes exactly KICK_PERIOD apart.
    localparam logic [PW-1:0]   PCNT_LOAD  = PW'(KICK_PERIOD - 2);
    localparam logic [GW-1:0]   GCNT_LOAD  = GW'(GRACE - 1);
    localparam logic [RW-1:0]   RCNT_LOAD  = RW'(RST_LEN - 1);
    localparam logic [NBIT-1:0] RELOAD_VAL = NBIT'(RELOAD);

    wdt_state_t state, state_nxt;
    logic       hb_seen;
    logic       p_load, p_dec, p_zero;
    logic       g_load, g_dec, g_zero;
    logic       r_load, r_dec, r_zero;
    wdt_bus_t   bus;
    logic       unused_dout;

    wdt_kick_timer #(.W(PW)) u_pcnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (p_load),
        .val_i  (PCNT_LOAD),
        .dec_i  (p_dec),
        .zero_o (p_zero)
    );

    wdt_kick_timer #(.W(GW)) u_gcnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (g_load),
        .val_i  (GCNT_LOAD),
        .dec_i  (g_dec),
        .zero_o (g_zero)
    );

    wdt_kick_timer #(.W(RW)) u_rcnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (r_load),
        .val_i  (RCNT_LOAD),
        .dec_i  (r_dec),
        .zero_o (r_zero)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and counter control; timeout beats disable beats period expiry.
    always_comb begin
        state_nxt = state;
        p_load    = 1'b0;
        p_dec     = 1'b0;
        g_load    = 1'b0;
        g_dec     = 1'b0;
        r_load    = 1'b0;
        r_dec     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_i) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM, ST_KICK: begin
                p_load = 1'b1;
                if (wd_to_i) begin
                    state_nxt = ST_ESCAL;
                    g_load    = 1'b1;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                p_dec = 1'b1;
                if (wd_to_i) begin
                    state_nxt = ST_ESCAL;
                    g_load    = 1'b1;
                end else if (!en_i) begin
                    state_nxt = ST_DISARM;
                end else if (p_zero) begin
                    state_nxt = (hb_seen || heartbeat_i) ? ST_KICK : ST_STARVE;
                end
            end
            ST_STARVE: begin
                if (wd_to_i) begin
                    state_nxt = ST_ESCAL;
                    g_load    = 1'b1;
                end else if (!en_i) begin
                    state_nxt = ST_DISARM;
                end
            end
            ST_DISARM: begin
                if (wd_to_i) begin
                    state_nxt = ST_ESCAL;
                    g_load    = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ESCAL: begin
                g_dec = 1'b1;
                if (g_zero) begin
                    state_nxt = ST_RESET;
                    r_load    = 1'b1;
                end
            end
            ST_RESET: begin
                r_dec = 1'b1;
                if (r_zero) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Heartbeat latch: restarted by each write cycle, set by any pulse in WAIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hb_seen <= 1'b0;
        end else begin
            case (state)
                ST_ARM, ST_KICK: hb_seen <= heartbeat_i;
                ST_WAIT:         if (heartbeat_i) hb_seen <= 1'b1;
                ST_IDLE:         hb_seen <= 1'b0;
                default:         hb_seen <= hb_seen;
            endcase
        end
    end

    // Outputs decoded from state: bus write record, reset request, activity.
    always_comb begin
        bus       = '0;
        rst_req_o = 1'b0;
        active_o  = 1'b0;
        case (state)
            ST_ARM, ST_KICK: begin
                bus.addr = WDT_RELOAD_ADDR;
                bus.dout = WDT_MAX_NBIT'(RELOAD_VAL);
                bus.req  = 1'b1;
                bus.we   = 1'b1;
                active_o = 1'b1;
            end
            ST_DISARM: begin
                bus.addr = WDT_RELOAD_ADDR;
                bus.req  = 1'b1;
                bus.we   = 1'b1;
            end
            ST_WAIT, ST_STARVE: active_o = 1'b1;
            ST_RESET:           rst_req_o = 1'b1;
            default: begin
                bus       = '0;
                rst_req_o = 1'b0;
            end
        endcase
    end

    assign wd_addr_o   = bus.addr;
    assign wd_dout_o   = bus.dout[NBIT-1:0];
    assign wd_req_o    = bus.req;
    assign wd_we_o     = bus.we;
    assign unused_dout = ^bus.dout;

`ifdef WDT_KICKER_STATUS_EN
    // Status: saturating kick/starve counts and a last-cycle-timed-out flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kick_cnt_o   <= '0;
            starve_cnt_o <= '0;
            last_to_o    <= 1'b0;
        end else begin
            if ((state == ST_KICK) && (kick_cnt_o != 16'hFFFF)) begin
                kick_cnt_o <= kick_cnt_o + 16'd1;
            end
            if ((state == ST_WAIT) && (state_nxt == ST_STARVE) && (starve_cnt_o != 8'hFF)) begin
                starve_cnt_o <= starve_cnt_o + 8'd1;
            end
            if ((state != ST_ESCAL) && (state_nxt == ST_ESCAL)) begin
                last_to_o <= 1'b1;
            end else if ((state != ST_ARM) && (state_nxt == ST_ARM)) begin
                last_to_o <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/wdt_kicker.md
Name: wdt_kicker

Overview:
- Bus-side initiator for the watchdog timer: drives the watchdog write interface (addr/din/req/we) with periodic reload writes ("kicks"), gated by a software heartbeat.
- Stops kicking when the heartbeat goes missing, letting the watchdog expire.
- On watchdog timeout, waits a grace period, then asserts a timed reset request back into the watchdog's reset-request input.
- Sits between the CPU-side liveness signal and the watchdog in the SoC reset/safety path.

Parameters:
- NBIT, 32, width of the watchdog data bus and reload value.
- RELOAD, 1000, value written to the watchdog on arm/kick; must exceed KICK_PERIOD.
- KICK_PERIOD, 256, cycles between consecutive kick writes; at least 2.
- GRACE, 16, cycles from timeout detection to reset-request assertion; at least 1.
- RST_LEN, 8, cycles rst_req_o is held high; at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- en_i  in  1  heartbeat supervision enable, level.
- heartbeat_i  in  1  single-cycle software-alive pulse.
- wd_addr_o  out  4  watchdog register address; 4'b0100 during writes, else 0.
- wd_dout_o  out  NBIT  write data to the watchdog.
- wd_req_o  out  1  watchdog access request.
- wd_we_o  out  1  watchdog write enable.
- wd_to_i  in  1  watchdog timeout flag (level, sticky until the next write).
- rst_req_o  out  1  reset request to the watchdog / reset generator.
- active_o  out  1  high in ARM, WAIT, KICK, STARVE.

Behaviour:
- Reset: state IDLE. All outputs are 0. Period counter, grace counter and hb_seen are cleared.
- Write cycle (states ARM, KICK, DISARM): wd_req_o=wd_we_o=1 for exactly one cycle, wd_addr_o=4'b0100. wd_dout_o=RELOAD in ARM/KICK and 0 in DISARM. Outside write cycles wd_dout_o=0.
- States: IDLE, ARM, WAIT, KICK, STARVE, DISARM, ESCAL, RESET.
- IDLE: go to ARM when en_i=1.
- ARM and KICK (one cycle each):
  - load pcnt=KICK_PERIOD-2;
  - hb_seen <= heartbeat_i;
  - go to WAIT.
- Kick spacing: consecutive kick write cycles are exactly KICK_PERIOD cycles apart.
- WAIT:
  - heartbeat_i sets hb_seen.
  - If pcnt!=0, decrement pcnt.
  - If pcnt==0, go to KICK when hb_seen is set or heartbeat_i is high in the same cycle; otherwise go to STARVE.
- STARVE: issue no writes. heartbeat_i does NOT revive; the only exits are a timeout or disable.
- en_i=0 in WAIT or STARVE: go to DISARM (writes 0, which stops the watchdog counter), then IDLE. en_i is ignored in ARM and KICK; it is re-evaluated in the next state.
- Timeout:
  - wd_to_i=1 in ARM, WAIT, KICK, STARVE or DISARM: go to ESCAL, gcnt=GRACE-1.
  - Priority: wd_to_i > en_i drop > period expiry.
- ESCAL:
  - Counts gcnt down; at 0 go to RESET, rcnt=RST_LEN-1.
  - No bus writes; en_i and heartbeat_i are ignored.
- RESET: rst_req_o=1 for exactly RST_LEN cycles, then IDLE with rst_req_o=0.
- wd_to_i in IDLE is ignored.
- rst_i mid-operation: synchronous return to IDLE. rst_req_o and wd_req_o drop the next edge.
- Width rules:
  - pcnt, gcnt and rcnt are sized by $clog2 of their parameter, minimum 1 bit.
  - RELOAD is truncated to NBIT.
  - Elaboration error if RELOAD<=KICK_PERIOD, KICK_PERIOD<2, GRACE<1 or RST_LEN<1.

Optional Feature:
- Macro: WDT_KICKER_STATUS_EN.
- When defined, add outputs:
  - kick_cnt_o [15:0]: saturating count of KICK writes.
  - starve_cnt_o [7:0]: saturating count of WAIT->STARVE transitions.
  - last_to_o: set on entry to ESCAL, cleared on entry to ARM.
  - All three reset to 0.
- When undefined, these ports and registers are absent; core behaviour is identical.

Decomposition:
- Shared package wdt_pkg:
  - state enum (8 states, 3 bits);
  - WDT_RELOAD_ADDR = 4'b0100;
  - write-cycle bus struct (addr, dout, req, we).
- One natural sub-module, wdt_kick_timer: a loadable down-counter with a zero flag, instantiated for pcnt, gcnt and rcnt.
- FSM and bus drive stay in wdt_kicker.

Test Plan:
All scenarios use RELOAD=100, KICK_PERIOD=16, GRACE=4, RST_LEN=8.
1. rst_i, then en_i=1 at cycle 0 -> ARM write at cycle 1 (addr 4'b0100, dout 100), active_o=1, next check at cycle 17.
2. heartbeat_i pulsed once per window -> KICK writes at cycles 17, 33, 49, each dout=100. A real watchdog model driven by wd_addr_o/wd_dout_o/wd_req_o/wd_we_o never raises wd_to_i.
3. Heartbeat stops after the KICK at cycle 33 -> WAIT->STARVE at cycle 48, no write at cycle 49. The watchdog asserts wd_to_i; ESCAL lasts 4 cycles; rst_req_o is high for exactly 8 cycles; then IDLE.
4. en_i dropped during WAIT -> one DISARM write with dout=0 on the next cycle, then IDLE. wd_to_i never asserts, and no further writes occur.
5. wd_to_i forced on the same cycle as en_i=0 and pcnt==0 -> ESCAL is taken (no DISARM or KICK). rst_i asserted mid-RESET -> rst_req_o=0 the next cycle.
6. Heartbeat arriving on the pcnt==0 cycle -> KICK, not STARVE. Heartbeat arriving during the KICK cycle -> counted for the next window.
